// File: rtl/i2c_pkg.sv
// Shared encodings for the ADS1115 command sequencer: master commands,
// sequencer states and the step-table entry format.
package i2c_pkg;

  localparam logic [2:0] CMD_NONE      = 3'd0;
  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_SEND      = 3'd2;
  localparam logic [2:0] CMD_RECV_ACK  = 3'd3;
  localparam logic [2:0] CMD_RECV_NACK = 3'd4;
  localparam logic [2:0] CMD_STOP      = 3'd5;

  // Which parameter a SEND step transmits
  localparam logic [2:0] WS_NONE     = 3'd0;
  localparam logic [2:0] WS_AW       = 3'd1;
  localparam logic [2:0] WS_AR       = 3'd2;
  localparam logic [2:0] WS_PTR_CFG  = 3'd3;
  localparam logic [2:0] WS_PTR_CONV = 3'd4;
  localparam logic [2:0] WS_CFG_HI   = 3'd5;
  localparam logic [2:0] WS_CFG_LO   = 3'd6;

  typedef enum logic [1:0] {
    SEQ_RECOVER = 2'd0,
    SEQ_CFG     = 2'd1,
    SEQ_IDLE    = 2'd2,
    SEQ_READ    = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_PARK    = 2'd0,
    PH_ISSUE   = 2'd1,
    PH_WAIT_HI = 2'd2,
    PH_WAIT_LO = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    TBL_RECOVER = 2'd0,
    TBL_CFG     = 2'd1,
    TBL_READ    = 2'd2
  } tbl_sel_e;

  typedef struct packed {
    logic [2:0] cmd;
    logic [2:0] wsel;
    logic       cap_hi;
    logic       cap_lo;
    logic       last;
  } step_t;

  function automatic step_t mk_step(logic [2:0] cmd, logic [2:0] wsel,
                                    logic cap_hi, logic cap_lo, logic last);
    return {cmd, wsel, cap_hi, cap_lo, last};
  endfunction

endpackage

// File: rtl/i2c_adc_seq_if.sv
// Byte-level command handshake between the sequencer (master side) and the
// i2c_rw bus engine (slave side).
interface i2c_adc_seq_if;
  logic       go;
  logic [2:0] cmd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;

  modport master (output go, cmd, wdata, input rdata, busy);
  modport slave  (input go, cmd, wdata, output rdata, busy);
endinterface

// File: rtl/i2c_step_rom.sv
// Command step tables for bus recovery, ADC configuration and conversion readout.
module i2c_step_rom
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter logic [15:0] CFG_WORD = 16'hC283,
  parameter logic [7:0]  PTR_CFG  = 8'h01,
  parameter logic [7:0]  PTR_CONV = 8'h00
) (
  input  tbl_sel_e   i_tbl,
  input  logic [3:0] i_step,
  output step_t      o_entry,
  output logic [7:0] o_wdata
);

  always_comb begin
    o_entry = mk_step(CMD_STOP, WS_NONE, 1'b0, 1'b0, 1'b1);
    case (i_tbl)
      TBL_CFG: begin
        case (i_step)
          4'd0:    o_entry = mk_step(CMD_START, WS_NONE,    1'b0, 1'b0, 1'b0);
          4'd1:    o_entry = mk_step(CMD_SEND,  WS_AW,      1'b0, 1'b0, 1'b0);
          4'd2:    o_entry = mk_step(CMD_SEND,  WS_PTR_CFG, 1'b0, 1'b0, 1'b0);
          4'd3:    o_entry = mk_step(CMD_SEND,  WS_CFG_HI,  1'b0, 1'b0, 1'b0);
          4'd4:    o_entry = mk_step(CMD_SEND,  WS_CFG_LO,  1'b0, 1'b0, 1'b0);
          default: o_entry = mk_step(CMD_STOP,  WS_NONE,    1'b0, 1'b0, 1'b1);
        endcase
      end
      TBL_READ: begin
        case (i_step)
          4'd0:    o_entry = mk_step(CMD_START,     WS_NONE,     1'b0, 1'b0, 1'b0);
          4'd1:    o_entry = mk_step(CMD_SEND,      WS_AW,       1'b0, 1'b0, 1'b0);
          4'd2:    o_entry = mk_step(CMD_SEND,      WS_PTR_CONV, 1'b0, 1'b0, 1'b0);
          4'd3:    o_entry = mk_step(CMD_STOP,      WS_NONE,     1'b0, 1'b0, 1'b0);
          4'd4:    o_entry = mk_step(CMD_START,     WS_NONE,     1'b0, 1'b0, 1'b0);
          4'd5:    o_entry = mk_step(CMD_SEND,      WS_AR,       1'b0, 1'b0, 1'b0);
          4'd6:    o_entry = mk_step(CMD_RECV_ACK,  WS_NONE,     1'b1, 1'b0, 1'b0);
          4'd7:    o_entry = mk_step(CMD_RECV_NACK, WS_NONE,     1'b0, 1'b1, 1'b0);
          default: o_entry = mk_step(CMD_STOP,      WS_NONE,     1'b0, 1'b0, 1'b1);
        endcase
      end
      default: o_entry = mk_step(CMD_STOP, WS_NONE, 1'b0, 1'b0, 1'b1);
    endcase
  end

  always_comb begin
    o_wdata = 8'h00;
    case (o_entry.wsel)
      WS_AW:       o_wdata = {DEV_ADDR, 1'b0};
      WS_AR:       o_wdata = {DEV_ADDR, 1'b1};
      WS_PTR_CFG:  o_wdata = PTR_CFG;
      WS_PTR_CONV: o_wdata = PTR_CONV;
      WS_CFG_HI:   o_wdata = CFG_WORD[15:8];
      WS_CFG_LO:   o_wdata = CFG_WORD[7:0];
      default:     o_wdata = 8'h00;
    endcase
  end

endmodule

// File: rtl/i2c_adc_seq.sv
// Sequencer driving an i2c_rw master: one-time ADC configuration, then periodic
// 16-bit conversion reads presented as o_sample with a one-cycle strobe.
// state   | meaning
// RECOVER | wait for bus idle, issue one STOP, then configure
// CFG     | write CFG_WORD to the config register, then set o_cfg_done
// IDLE    | wait for enable and period elapsed
// READ    | pointer write + 2-byte read of the conversion register
module i2c_adc_seq
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter logic [15:0] CFG_WORD = 16'hC283,
  parameter logic [7:0]  PTR_CFG  = 8'h01,
  parameter logic [7:0]  PTR_CONV = 8'h00,
  parameter int unsigned PERIOD   = 120000,
  parameter int unsigned BUSY_TMO = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  i2c_adc_seq_if.master        io_i2c,
  output logic [15:0]          o_sample,
  output logic                 o_sample_valid,
  output logic                 o_cfg_done,
  output logic                 o_err
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int TMO_W = $clog2(BUSY_TMO + 1);
  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(BUSY_TMO);

  seq_state_e       r_state, w_state_nxt;
  phase_e           r_phase, w_phase_nxt;
  logic [3:0]       r_step, w_step_nxt;
  logic [CNT_W-1:0] r_period_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_go;
  logic [2:0]       r_cmd;
  logic [7:0]       r_wdata;
  logic [7:0]       r_hi, r_lo;
  logic [15:0]      r_sample;
  logic             r_sample_valid, r_cfg_done, r_err;

  tbl_sel_e   w_tbl;
  step_t      w_entry;
  logic [7:0] w_rom_wdata;
  logic       w_issue, w_step_done, w_tmo, w_start_read;

  always_comb begin
    w_tbl = TBL_RECOVER;
    if (r_state == SEQ_CFG)       w_tbl = TBL_CFG;
    else if (r_state == SEQ_READ) w_tbl = TBL_READ;
  end

  i2c_step_rom #(
    .DEV_ADDR (DEV_ADDR),
    .CFG_WORD (CFG_WORD),
    .PTR_CFG  (PTR_CFG),
    .PTR_CONV (PTR_CONV)
  ) u_rom (
    .i_tbl   (w_tbl),
    .i_step  (r_step),
    .o_entry (w_entry),
    .o_wdata (w_rom_wdata)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_step_nxt   = r_step;
    w_issue      = 1'b0;
    w_step_done  = 1'b0;
    w_tmo        = 1'b0;
    w_start_read = 1'b0;
    if (r_state == SEQ_IDLE) begin
      if (i_enable && (r_period_cnt >= PERIOD_M1)) begin
        w_start_read = 1'b1;
        w_state_nxt  = SEQ_READ;
        w_phase_nxt  = PH_ISSUE;
        w_step_nxt   = 4'd0;
      end
    end else begin
      case (r_phase)
        PH_PARK: if (!io_i2c.busy) w_phase_nxt = PH_ISSUE;
        PH_ISSUE: begin
          w_issue     = 1'b1;
          w_phase_nxt = PH_WAIT_HI;
        end
        PH_WAIT_HI: begin
          if (io_i2c.busy) begin
            w_phase_nxt = PH_WAIT_LO;
          end else if (r_tmo_cnt == '0) begin
            w_tmo       = 1'b1;
            w_state_nxt = SEQ_RECOVER;
            w_phase_nxt = PH_PARK;
            w_step_nxt  = 4'd0;
          end
        end
        default: begin
          if (!io_i2c.busy) begin
            w_step_done = 1'b1;
            w_phase_nxt = PH_ISSUE;
            if (w_entry.last) begin
              w_step_nxt  = 4'd0;
              w_state_nxt = (r_state == SEQ_RECOVER) ? SEQ_CFG : SEQ_IDLE;
            end else begin
              w_step_nxt = r_step + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= SEQ_RECOVER;
      r_phase        <= PH_PARK;
      r_step         <= 4'd0;
      r_period_cnt   <= '0;
      r_tmo_cnt      <= '0;
      r_go           <= 1'b0;
      r_cmd          <= CMD_NONE;
      r_wdata        <= 8'h00;
      r_hi           <= 8'h00;
      r_lo           <= 8'h00;
      r_sample       <= 16'h0000;
      r_sample_valid <= 1'b0;
      r_cfg_done     <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_phase        <= w_phase_nxt;
      r_step         <= w_step_nxt;
      r_go           <= w_issue;
      r_sample_valid <= 1'b0;
      if (w_issue) begin
        r_cmd     <= w_entry.cmd;
        r_wdata   <= (w_entry.wsel != WS_NONE) ? w_rom_wdata : 8'h00;
        r_tmo_cnt <= TMO_LOAD;
      end else if ((r_phase == PH_WAIT_HI) && (r_tmo_cnt != '0)) begin
        r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
      end
      // Saturating so an overrun READ restarts immediately on return to IDLE
      if (w_start_read)                 r_period_cnt <= '0;
      else if (r_period_cnt < PERIOD_M1) r_period_cnt <= r_period_cnt + CNT_W'(1);
      if (w_tmo) r_err <= 1'b1;
      if (w_step_done) begin
        if (w_entry.cap_hi) r_hi <= io_i2c.rdata;
        if (w_entry.cap_lo) r_lo <= io_i2c.rdata;
        if (w_entry.last && (r_state == SEQ_CFG)) r_cfg_done <= 1'b1;
        if (w_entry.last && (r_state == SEQ_READ)) begin
          r_sample       <= {r_hi, r_lo};
          r_sample_valid <= 1'b1;
        end
      end
    end
  end

  assign io_i2c.go    = r_go;
  assign io_i2c.cmd   = r_cmd;
  assign io_i2c.wdata = r_wdata;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;
  assign o_cfg_done     = r_cfg_done;
  assign o_err          = r_err;

endmodule
